// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the hbus-to-Wishbone responder.
package hyperbus_pkg;

  localparam int WB_DATA_WIDTH   = 32;
  localparam int WB_ADDR_WIDTH   = 32;
  localparam int HBUS_ADDR_WIDTH = 32;
  localparam int HBUS_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_CYC     = 3'b010,
    ST_BACKOFF = 3'b100
  } state_t;

  localparam logic [HBUS_DATA_WIDTH-1:0] ERR_DATA    = 16'hDEAD;
  localparam logic [2:0]                 CTI_CLASSIC = 3'b000;
  localparam logic [1:0]                 BTE_LINEAR  = 2'b00;

  // Halfword lane select: adr[1] picks the upper pair; mask bit 1 = byte not written.
  function automatic logic [3:0] lane_sel(input logic adr1, input logic [1:0] mask);
    return adr1 ? {~mask, 2'b00} : {2'b00, ~mask};
  endfunction

endpackage

// File: rtl/hyperbus_if.sv
// hbus request port plus Wishbone master port; master = responder view, slave = environment view.
interface hyperbus_if;
  import hyperbus_pkg::*;

  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i;
  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i;
  logic [1:0]                 hbus_mask_i;
  logic                       hbus_rrq;
  logic                       hbus_wrq;
  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o;
  logic                       hbus_ready;
  logic                       hbus_valid;
  logic [WB_ADDR_WIDTH-1:0]   wb_adr_o;
  logic [WB_DATA_WIDTH-1:0]   wb_dat_o;
  logic [3:0]                 wb_sel_o;
  logic                       wb_we_o;
  logic                       wb_cyc_o;
  logic                       wb_stb_o;
  logic [2:0]                 wb_cti_o;
  logic [1:0]                 wb_bte_o;
  logic [WB_DATA_WIDTH-1:0]   wb_dat_i;
  logic                       wb_ack_i;
  logic                       wb_err_i;
  logic                       wb_rty_i;
  logic                       err_o;
  logic                       err_clr_i;

  modport master (
    input  hbus_adr_i, hbus_dat_i, hbus_mask_i, hbus_rrq, hbus_wrq,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, err_clr_i,
    output hbus_dat_o, hbus_ready, hbus_valid,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    output err_o
  );

  modport slave (
    output hbus_adr_i, hbus_dat_i, hbus_mask_i, hbus_rrq, hbus_wrq,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, err_clr_i,
    input  hbus_dat_o, hbus_ready, hbus_valid,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
    input  err_o
  );

endinterface

// File: rtl/hyperbus_down_counter.sv
// Loadable saturating down counter; zero flag is combinational from the count.
module hyperbus_down_counter #(
  parameter int W = 8
) (
  input  logic         wb_clk,
  input  logic         wb_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n)               cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hyperbus_wb_master.sv
// Runs each hbus read/write pulse as one classic 32-bit Wishbone cycle with retry backoff,
// timeout abort and a sticky error flag; hbus_ready is low while a request is in flight.
module hyperbus_wb_master
  import hyperbus_pkg::*;
#(
  parameter int TIMEOUT     = 255,
  parameter int MAX_RETRY   = 3,
  parameter int RETRY_DELAY = 4
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  hyperbus_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int BW = $clog2(RETRY_DELAY + 1);

  state_t state, state_nxt;

  logic req_any, accept, skip, err_set;
  logic done, fail, retry, to_load, bo_load, to_zero, bo_zero;
  logic [RW-1:0]              retry_cnt;
  logic [WB_ADDR_WIDTH-1:0]   adr_q;
  logic [WB_DATA_WIDTH-1:0]   dat_q;
  logic [3:0]                 sel_q;
  logic                       we_q, adr1_q, valid_q, err_q;
  logic [HBUS_DATA_WIDTH-1:0] rd_q;

  assign req_any = bus.hbus_rrq | bus.hbus_wrq;
  assign accept  = (state == ST_IDLE) && req_any;
  // A fully masked write touches no byte lane, so it completes without a bus cycle.
  assign skip    = accept && bus.hbus_wrq && (bus.hbus_mask_i == 2'b11);
  assign err_set = fail || (req_any && state != ST_IDLE) || (accept && bus.hbus_rrq && bus.hbus_wrq);

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    fail      = 1'b0;
    retry     = 1'b0;
    to_load   = 1'b0;
    bo_load   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept && !skip) begin
          state_nxt = ST_CYC;
          to_load   = 1'b1;
        end
      end
      ST_CYC: begin
        if (bus.wb_err_i) begin
          done = 1'b1;
          fail = 1'b1;
        end else if (bus.wb_ack_i) begin
          done = 1'b1;
        end else if (bus.wb_rty_i) begin
          if (retry_cnt < RW'(MAX_RETRY)) begin
            retry     = 1'b1;
            bo_load   = 1'b1;
            state_nxt = ST_BACKOFF;
          end else begin
            done = 1'b1;
            fail = 1'b1;
          end
        end else if (to_zero) begin
          done = 1'b1;
          fail = 1'b1;
        end
        if (done) state_nxt = ST_IDLE;
      end
      ST_BACKOFF: begin
        if (bo_zero) begin
          state_nxt = ST_CYC;
          to_load   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Loaded with N-1 so the zero flag lands on the Nth cycle in the state.
  hyperbus_down_counter #(.W(TW)) u_timeout (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .load     (to_load),
    .load_val (TW'(TIMEOUT - 1)),
    .dec      (state == ST_CYC),
    .zero     (to_zero)
  );

  hyperbus_down_counter #(.W(BW)) u_backoff (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .load     (bo_load),
    .load_val (BW'(RETRY_DELAY - 1)),
    .dec      (state == ST_BACKOFF),
    .zero     (bo_zero)
  );

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      adr1_q    <= 1'b0;
      retry_cnt <= '0;
      valid_q   <= 1'b0;
      rd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        adr_q     <= {bus.hbus_adr_i[31:2], 2'b00};
        dat_q     <= {2{bus.hbus_dat_i}};
        sel_q     <= lane_sel(bus.hbus_adr_i[1], bus.hbus_wrq ? bus.hbus_mask_i : 2'b00);
        we_q      <= bus.hbus_wrq;
        adr1_q    <= bus.hbus_adr_i[1];
        retry_cnt <= '0;
      end
      if (retry) retry_cnt <= retry_cnt + RW'(1);
      if (done && !we_q) begin
        valid_q <= 1'b1;
        rd_q    <= fail ? ERR_DATA : (adr1_q ? bus.wb_dat_i[31:16] : bus.wb_dat_i[15:0]);
      end
      if (err_set)            err_q <= 1'b1;
      else if (bus.err_clr_i) err_q <= 1'b0;
    end
  end

  assign bus.hbus_ready = (state == ST_IDLE);
  assign bus.hbus_valid = valid_q;
  assign bus.hbus_dat_o = rd_q;
  assign bus.wb_adr_o   = adr_q;
  assign bus.wb_dat_o   = dat_q;
  assign bus.wb_sel_o   = sel_q;
  assign bus.wb_we_o    = we_q;
  assign bus.wb_cyc_o   = (state == ST_CYC);
  assign bus.wb_stb_o   = (state == ST_CYC);
  assign bus.wb_cti_o   = CTI_CLASSIC;
  assign bus.wb_bte_o   = BTE_LINEAR;
  assign bus.err_o      = err_q;

endmodule
